// File: rtl/lane_pkg.sv
// lane_pkg: shared widths, lane indices, light-bit mapping and per-lane state for the queue tracker.
package lane_pkg;
  localparam int NUM_LANES = 8;
  localparam int COUNT_W = 8;
  typedef logic [COUNT_W-1:0] count_t;
  localparam int LANE_N1 = 0;
  localparam int LANE_N2 = 1;
  localparam int LANE_E1 = 2;
  localparam int LANE_E2 = 3;
  localparam int LANE_S1 = 4;
  localparam int LANE_S2 = 5;
  localparam int LANE_W1 = 6;
  localparam int LANE_W2 = 7;
  typedef enum logic [1:0] {IDLE, WAITING, DRAINING} lane_state_t;
  // The controller drives its lights MSB-first, so lane i sits at bit 7-i.
  function automatic int green_bit(input int lane);
    return NUM_LANES - 1 - lane;
  endfunction
endpackage

// File: rtl/lane_counter.sv
// lane_counter: one lane's arrival edge detect, departure timer and saturating queue count.
// Optional LANE_TRACKER_SYNC_EN adds a two-flop synchronizer on arrive.
module lane_counter
  import lane_pkg::*;
#(
  parameter int DEPART_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   arrive,
  input  logic   green,
  output count_t count,
  output logic   nonempty
);
  localparam logic [7:0] TLAST = 8'(DEPART_CYCLES - 1);
  logic smp, prev, rise, depart, inc;
  logic [7:0] timer, timer_nxt;
  count_t count_nxt;
  lane_state_t state;
`ifdef LANE_TRACKER_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], arrive};
  assign smp = sync[1];
`else
  assign smp = arrive;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev     <= 1'b0;
      timer    <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      prev     <= smp;
      timer    <= timer_nxt;
      count    <= count_nxt;
      nonempty <= count_nxt != '0;
    end
  always_comb state = count == '0 ? IDLE : green ? DRAINING : WAITING;
  // An arrival landing on a departure cycle cancels it; a full queue drops arrivals.
  always_comb begin
    rise      = smp & ~prev;
    depart    = state == DRAINING && timer == TLAST;
    inc       = rise && count != '1;
    count_nxt = rise && depart ? count : depart ? count - 1'b1 : inc ? count + 1'b1 : count;
    timer_nxt = state != DRAINING || depart ? '0 : timer + 1'b1;
  end
endmodule

// File: rtl/lane_queue_tracker.sv
// lane_queue_tracker: eight independent lane queue counters feeding the traffic-light controller.
// Define LANE_TRACKER_SYNC_EN to synchronize arrive inside each lane.
module lane_queue_tracker
  import lane_pkg::*;
#(
  parameter int DEPART_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_LANES-1:0]      arrive,
  input  logic [NUM_LANES-1:0]      lane_green,
  output logic [NUM_LANES-1:0][7:0] car_counts,
  output logic [NUM_LANES-1:0]      nonempty
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_counter #(.DEPART_CYCLES(DEPART_CYCLES)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .arrive   (arrive[i]),
      .green    (lane_green[green_bit(i)]),
      .count    (car_counts[i]),
      .nonempty (nonempty[i])
    );
  end
endmodule

// File: tb/tb_lane_queue_tracker.sv
// tb_lane_queue_tracker: directed checks of arrivals, draining, saturation, simultaneity and reset.
module tb_lane_queue_tracker;
`ifdef LANE_TRACKER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] arrive = '0;
  logic [7:0] lane_green = '0;
  logic [7:0][7:0] car_counts;
  logic [7:0] nonempty;
  int n_cmp = 0;
  int n_bad = 0;

  lane_queue_tracker #(.DEPART_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arrive     (arrive),
    .lane_green (lane_green),
    .car_counts (car_counts),
    .nonempty   (nonempty)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int lane, input int n);
    repeat (n) begin
      arrive[lane] = 1'b1;
      step();
      arrive[lane] = 1'b0;
      step();
    end
    step(LAT);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step(2);
    n_cmp++;
    if (car_counts !== 64'd0) begin n_bad++; $display("FAIL reset_counts: got %h expected 0", car_counts); end
    n_cmp++;
    if (nonempty !== 8'd0) begin n_bad++; $display("FAIL reset_nonempty: got %b expected 00000000", nonempty); end
    rst_n = 1'b1;
    step(2);
    n_cmp++;
    if (car_counts !== 64'd0) begin n_bad++; $display("FAIL post_reset_counts: got %h expected 0", car_counts); end
  endtask

  task automatic test_arrival_latency();
    arrive[3] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      arrive[3] = 1'b0;
      n_cmp++;
      if (car_counts[3] !== 8'(k >= LAT + 1)) begin
        n_bad++; $display("FAIL latency_k%0d: got %0d expected %0d", k, car_counts[3], k >= LAT + 1);
      end
    end
    do_reset();
  endtask

  task automatic test_arrivals();
    pulse(1, 3);
    arrive[2] = 1'b1;
    step(10);
    arrive[2] = 1'b0;
    step(LAT + 1);
    n_cmp++;
    if (car_counts[1] !== 8'd3) begin n_bad++; $display("FAIL arr_lane1: got %0d expected 3", car_counts[1]); end
    n_cmp++;
    if (car_counts[2] !== 8'd1) begin n_bad++; $display("FAIL arr_lane2_held: got %0d expected 1", car_counts[2]); end
    n_cmp++;
    if (nonempty !== 8'b00000110) begin n_bad++; $display("FAIL arr_nonempty: got %b expected 00000110", nonempty); end
  endtask

  task automatic test_mid_reset();
    step();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (car_counts !== 64'd0) begin n_bad++; $display("FAIL mid_reset_counts: got %h expected 0", car_counts); end
    n_cmp++;
    if (nonempty !== 8'd0) begin n_bad++; $display("FAIL mid_reset_nonempty: got %b expected 0", nonempty); end
    arrive[4] = 1'b1;
    #1 rst_n = 1'b1;
    step(1 + LAT);
    arrive[4] = 1'b0;
    n_cmp++;
    if (car_counts[4] !== 8'd1) begin n_bad++; $display("FAIL release_level_edge: got %0d expected 1", car_counts[4]); end
  endtask

  task automatic test_drain();
    do_reset();
    pulse(6, 27);
    n_cmp++;
    if (car_counts[6] !== 8'd27) begin n_bad++; $display("FAIL drain_fill: got %0d expected 27", car_counts[6]); end
    lane_green = 8'b00000010;
    step(3);
    n_cmp++;
    if (car_counts[6] !== 8'd27) begin n_bad++; $display("FAIL drain_before_first: got %0d expected 27", car_counts[6]); end
    step();
    n_cmp++;
    if (car_counts[6] !== 8'd26) begin n_bad++; $display("FAIL drain_first: got %0d expected 26", car_counts[6]); end
    step(16);
    n_cmp++;
    if (car_counts[6] !== 8'd22) begin n_bad++; $display("FAIL drain_20cyc: got %0d expected 22", car_counts[6]); end
    step(3);
    lane_green = 8'b00000000;
    step(5);
    n_cmp++;
    if (car_counts[6] !== 8'd22) begin n_bad++; $display("FAIL drain_drop_hold: got %0d expected 22", car_counts[6]); end
    lane_green = 8'b00000010;
    step();
    n_cmp++;
    if (car_counts[6] !== 8'd22) begin n_bad++; $display("FAIL drain_progress_lost: got %0d expected 22", car_counts[6]); end
    step(3);
    n_cmp++;
    if (car_counts[6] !== 8'd21) begin n_bad++; $display("FAIL drain_resume: got %0d expected 21", car_counts[6]); end
    n_cmp++;
    if (nonempty[6] !== 1'b1) begin n_bad++; $display("FAIL drain_nonempty: got %b expected 1", nonempty[6]); end
    lane_green = 8'b00000000;
  endtask

  task automatic test_saturation();
    do_reset();
    pulse(0, 260);
    n_cmp++;
    if (car_counts[0] !== 8'd255) begin n_bad++; $display("FAIL sat_260: got %0d expected 255", car_counts[0]); end
    pulse(0, 1);
    n_cmp++;
    if (car_counts[0] !== 8'd255) begin n_bad++; $display("FAIL sat_plus1: got %0d expected 255", car_counts[0]); end
    n_cmp++;
    if (car_counts[1] !== 8'd0) begin n_bad++; $display("FAIL sat_neighbor: got %0d expected 0", car_counts[1]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(7, 1);
    lane_green = 8'b00000001;
    step(3 - LAT);
    arrive[7] = 1'b1;
    step();
    arrive[7] = 1'b0;
    step(LAT);
    n_cmp++;
    if (car_counts[7] !== 8'd1) begin n_bad++; $display("FAIL simul_count: got %0d expected 1", car_counts[7]); end
    step(3);
    n_cmp++;
    if (car_counts[7] !== 8'd1) begin n_bad++; $display("FAIL simul_timer_reset: got %0d expected 1", car_counts[7]); end
    step();
    n_cmp++;
    if (car_counts[7] !== 8'd0) begin n_bad++; $display("FAIL simul_still_draining: got %0d expected 0", car_counts[7]); end
    n_cmp++;
    if (nonempty[7] !== 1'b0) begin n_bad++; $display("FAIL simul_nonempty: got %b expected 0", nonempty[7]); end
    step(6);
    n_cmp++;
    if (car_counts[7] !== 8'd0) begin n_bad++; $display("FAIL idle_green_stays: got %0d expected 0", car_counts[7]); end
    lane_green = 8'b00000000;
  endtask

  initial begin
    test_reset();
    test_arrival_latency();
    test_arrivals();
    test_mid_reset();
    test_drain();
    test_saturation();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
